// File: rtl/cla_adder_32_pkg.sv
// Shared constants and types for the 32-bit carry-look-ahead adder.
package cla_adder_32_pkg;
    localparam int ADDER_WIDTH     = 32;
    localparam int CLA_BLOCK_WIDTH = 4;
    localparam int CLA_NUM_BLOCKS  = 8;

    // Group generate/propagate pair produced by each 4-bit block.
    typedef struct packed {
        logic g;
        logic p;
    } cla_gp_t;
endpackage

// File: rtl/cla_adder_32_block4.sv
// 4-bit look-ahead block: internal carries are flat sum-of-products of g, p and cin.
module cla_block4
    import cla_adder_32_pkg::*;
(
    input  logic [CLA_BLOCK_WIDTH-1:0] a,
    input  logic [CLA_BLOCK_WIDTH-1:0] b,
    input  logic                       cin,
    output logic [CLA_BLOCK_WIDTH-1:0] sum,
    output logic                       group_g,
    output logic                       group_p
);
    logic [CLA_BLOCK_WIDTH-1:0] g;
    logic [CLA_BLOCK_WIDTH-1:0] p;
    logic [CLA_BLOCK_WIDTH-1:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);

    assign sum     = p ^ c;
    assign group_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0]);
    assign group_p = &p;
endmodule

// File: rtl/cla_adder_32.sv
// 32-bit unsigned CLA adder: eight 4-bit blocks, a single-level group look-ahead
// unit across all blocks, and a registered {cout,sum}.
module cla_adder_32
    import cla_adder_32_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    output logic                   cout,
    output logic [ADDER_WIDTH-1:0] sum,
    input  logic [ADDER_WIDTH-1:0] a,
    input  logic [ADDER_WIDTH-1:0] b
);
    logic [CLA_NUM_BLOCKS-1:0][CLA_BLOCK_WIDTH-1:0] a_blk;
    logic [CLA_NUM_BLOCKS-1:0][CLA_BLOCK_WIDTH-1:0] b_blk;
    logic [CLA_NUM_BLOCKS-1:0][CLA_BLOCK_WIDTH-1:0] s_blk;
    cla_gp_t [CLA_NUM_BLOCKS-1:0]                   gp;
    logic [CLA_NUM_BLOCKS:0]                        c_blk;

    assign a_blk = a;
    assign b_blk = b;

    for (genvar i = 0; i < CLA_NUM_BLOCKS; i++) begin : g_blk
        cla_block4 u_blk (
            .a       (a_blk[i]),
            .b       (b_blk[i]),
            .cin     (c_blk[i]),
            .sum     (s_blk[i]),
            .group_g (gp[i].g),
            .group_p (gp[i].p)
        );
    end

    // Each block carry is an OR of GG terms masked by the GP run above them,
    // so every carry is two logic levels from the group terms (carry-in is 0).
    always_comb begin
        logic term;
        c_blk    = '0;
        term     = 1'b0;
        c_blk[0] = 1'b0;
        for (int j = 0; j < CLA_NUM_BLOCKS; j++) begin
            c_blk[j+1] = 1'b0;
            for (int i = 0; i <= j; i++) begin
                term = gp[i].g;
                for (int k = i + 1; k <= j; k++) begin
                    term = term & gp[k].p;
                end
                c_blk[j+1] = c_blk[j+1] | term;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= s_blk;
            cout <= c_blk[CLA_NUM_BLOCKS];
        end
    end
endmodule

// File: tb/tb_cla_adder_32.sv
// Scoreboard bench for cla_adder_32: driver queues expected {cout,sum}, monitor checks after each edge.
module tb_cla_adder_32;
    logic        clk;
    logic        reset;
    logic        cout;
    logic [31:0] sum;
    logic [31:0] a;
    logic [31:0] b;

    typedef struct {
        logic [32:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    cla_adder_32 dut (
        .clk   (clk),
        .reset (reset),
        .cout  (cout),
        .sum   (sum),
        .a     (a),
        .b     (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one queued expectation per driven edge, checked 1ns after it.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_tests++;
            if ({cout, sum} !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got cout=%b sum=%h, expected cout=%b sum=%h",
                         e.name, cout, sum, e.exp[32], e.exp[31:0]);
            end
        end
    end

    task automatic apply(input logic [31:0] va, input logic [31:0] vb,
                         input logic rst, input logic [32:0] exp, input string name);
        exp_t e;
        @(negedge clk);
        a     = va;
        b     = vb;
        reset = rst;
        e.exp  = exp;
        e.name = name;
        q.push_back(e);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [32:0] one;
        int          budget;
        one   = 33'd1;
        a     = '0;
        b     = '0;
        reset = 1'b0;

        apply(32'h0, 32'h0, 1'b1, 33'h0, "reset");
        apply(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33'h0, "reset_ops_ignored");

        for (int k = 0; k < 32; k++)
            apply(32'd1 << k, 32'd1 << k, 1'b0, one << (k + 1), $sformatf("double_k%0d", k));

        for (int k = 0; k < 32; k++)
            apply(32'd1 << k, 32'h0, 1'b0, one << k, $sformatf("walk_a_k%0d", k));
        for (int k = 0; k < 32; k++)
            apply(32'h0, 32'd1 << k, 1'b0, one << k, $sformatf("walk_b_k%0d", k));

        apply(32'h00000000, 32'h00000000, 1'b0, 33'h000000000, "zero_zero");
        apply(32'h00000000, 32'hFFFFFFFF, 1'b0, 33'h0FFFFFFFF, "zero_ones");
        apply(32'hFFFFFFFF, 32'h00000000, 1'b0, 33'h0FFFFFFFF, "ones_zero");
        apply(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33'h1FFFFFFFE, "ones_ones");
        apply(32'hFFDF1F40, 32'h80031F4F, 1'b0, 33'h17FE23E8F, "vec1");
        apply(32'h07FA07FD, 32'h80C01F07, 1'b0, 33'h088BA2704, "vec2");
        apply(32'h23489ABC, 32'h12AFE847, 1'b0, 33'h035F88303, "vec3");

        // Mid-stream reset clears on its edge, then the same operands resume.
        apply(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33'h000000000, "midreset");
        apply(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33'h1FFFFFFFE, "post_reset");

        for (int n = 0; n < 100; n++) begin
            ra = $urandom();
            rb = $urandom();
            apply(ra, rb, 1'b0, {1'b0, ra} + {1'b0, rb}, $sformatf("b2b_%0d", n));
        end

        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
